// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, zero-register index and FSM state for the writeback stage
package wb_pkg;
    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 4;
    localparam int ZERO_REG       = 0;
    typedef enum logic {IDLE, MEM_WAIT} state_t;
endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: counts stalled MEM_WAIT cycles; done marks the last cycle before abandon
module wb_timeout_counter #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic done
);
    localparam int CW = $clog2(MAX + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= clear ? '0 : en ? cnt + 1'b1 : cnt;
    end
    // Incrementing on this cycle would reach MAX
    assign done = (cnt == CW'(MAX - 1));
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: retires ALU results and loads into the register file; WB_FWD_EN adds fwd_* bypass outputs
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wr_en,
    input  logic                  in_is_load,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]     in_alu_result,
    output logic                  mem_req,
    output logic [DATA_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_write_Rd,
    output logic [DATA_W-1:0]     rf_write_data,
    output logic                  busy,
    output logic                  err_timeout
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data
`endif
);
    state_t                state, state_n;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  wr_q;
    logic                  done;
    logic                  accept, ld_acc, alu_wr, ld_wr, timeout, waiting;

    wb_timeout_counter #(.MAX(MEM_TIMEOUT)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .en    (waiting && !mem_ack),
        .done  (done)
    );

    assign waiting = (state == MEM_WAIT);
    assign accept  = in_valid && in_ready;
    assign ld_acc  = accept && in_is_load;
    assign alu_wr  = accept && !in_is_load && in_wr_en && (in_rd != REG_ADDR_W'(ZERO_REG));
    assign ld_wr   = waiting && mem_ack && wr_q && (rd_q != REG_ADDR_W'(ZERO_REG));
    // Ack wins over a timeout landing in the same cycle
    assign timeout = waiting && done && !mem_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE) ? (ld_acc ? MEM_WAIT : IDLE)
                                  : ((mem_ack || done) ? IDLE : MEM_WAIT);
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            rd_q          <= '0;
            wr_q          <= 1'b0;
            rf_wen        <= 1'b0;
            rf_write_Rd   <= '0;
            rf_write_data <= '0;
            err_timeout   <= 1'b0;
        end else begin
            mem_req       <= (state_n == MEM_WAIT);
            mem_addr      <= ld_acc ? in_alu_result : mem_addr;
            rd_q          <= ld_acc ? in_rd : rd_q;
            wr_q          <= ld_acc ? in_wr_en : wr_q;
            rf_wen        <= alu_wr || ld_wr;
            rf_write_Rd   <= ld_wr ? rd_q : alu_wr ? in_rd : rf_write_Rd;
            rf_write_data <= ld_wr ? mem_rdata : alu_wr ? in_alu_result : rf_write_data;
            err_timeout   <= timeout;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = rf_wen;
    assign fwd_rd    = rf_write_Rd;
    assign fwd_data  = rf_write_data;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed checks of writeback_unit (default timeout and MEM_TIMEOUT=4 instances)
module tb_writeback_unit;
    logic        clk, rst_n;
    logic        in_valid, in_wr_en, in_is_load, mem_ack;
    logic [3:0]  in_rd;
    logic [31:0] in_alu_result, mem_rdata;
    logic        in_ready, mem_req, rf_wen, busy, err_timeout;
    logic [31:0] mem_addr, rf_write_data;
    logic [3:0]  rf_write_Rd;
    logic        t_ready, t_mem_req, t_wen, t_busy, t_err;
    logic [31:0] t_mem_addr, t_data;
    logic [3:0]  t_rd;
`ifdef WB_FWD_EN
    logic        fwd_valid, t_fwd_valid;
    logic [3:0]  fwd_rd, t_fwd_rd;
    logic [31:0] fwd_data, t_fwd_data;
`endif
    int tests = 0;
    int fails = 0;

    writeback_unit u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_wr_en(in_wr_en), .in_is_load(in_is_load), .in_rd(in_rd),
        .in_alu_result(in_alu_result), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_wen(rf_wen),
        .rf_write_Rd(rf_write_Rd), .rf_write_data(rf_write_data), .busy(busy),
        .err_timeout(err_timeout)
`ifdef WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
    );

    writeback_unit #(.MEM_TIMEOUT(4)) u_tmo (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_ready),
        .in_wr_en(in_wr_en), .in_is_load(in_is_load), .in_rd(in_rd),
        .in_alu_result(in_alu_result), .mem_req(t_mem_req), .mem_addr(t_mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_wen(t_wen),
        .rf_write_Rd(t_rd), .rf_write_data(t_data), .busy(t_busy),
        .err_timeout(t_err)
`ifdef WB_FWD_EN
        , .fwd_valid(t_fwd_valid), .fwd_rd(t_fwd_rd), .fwd_data(t_fwd_data)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 0; in_wr_en = 0; in_is_load = 0; in_rd = 0; in_alu_result = 0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        idle_in();
        mem_ack = 0;
        for (int i = 0; i < n; i++) begin
            step();
            chk("rst_wen", rf_wen, 0);
            chk("rst_req", mem_req, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", in_ready, 1);
            chk("rst_err", err_timeout, 0);
        end
        rst_n = 1;
    endtask

    task automatic issue_load(input logic [3:0] rd, input logic [31:0] addr);
        in_valid = 1; in_wr_en = 1; in_is_load = 1; in_rd = rd; in_alu_result = addr;
        step();
        idle_in();
    endtask

`ifdef WB_FWD_EN
    always @(negedge clk) begin
        chk("fwd_valid", fwd_valid, rf_wen);
        chk("fwd_rd", fwd_rd, rf_write_Rd);
        chk("fwd_data", fwd_data, rf_write_data);
        chk("t_fwd", {t_fwd_valid, t_fwd_rd, t_fwd_data}, {t_wen, t_rd, t_data});
    end
`endif

    typedef struct {
        logic        valid;
        logic        wr_en;
        logic [3:0]  rd;
        logic [31:0] data;
        logic        exp_wen;
        logic [3:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, 1, 4'd1,  32'hA5A5A5A5, 1, 4'd1,  32'hA5A5A5A5};
        vecs[1] = '{1, 1, 4'd2,  32'h5A5A5A5A, 1, 4'd2,  32'h5A5A5A5A};
        vecs[2] = '{1, 1, 4'd3,  32'h0000FFFF, 1, 4'd3,  32'h0000FFFF};
        vecs[3] = '{0, 1, 4'd7,  32'h00001234, 0, 4'd0,  32'h0};
        vecs[4] = '{1, 1, 4'd0,  32'hFFFFFFFF, 0, 4'd0,  32'h0};
        vecs[5] = '{1, 0, 4'd5,  32'h11111111, 0, 4'd0,  32'h0};
        vecs[6] = '{1, 1, 4'd15, 32'h80000001, 1, 4'd15, 32'h80000001};
        mem_rdata = 0;
        do_reset(3);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("post_rst_ready", in_ready, 1);
            chk("post_rst_wen", rf_wen, 0);
            chk("post_rst_busy", busy, 0);
        end

        // back-to-back ALU retirements, one write per cycle
        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].valid; in_wr_en = vecs[i].wr_en; in_is_load = 0;
            in_rd = vecs[i].rd; in_alu_result = vecs[i].data;
            step();
            chk($sformatf("v%0d_wen", i), rf_wen, vecs[i].exp_wen);
            if (vecs[i].exp_wen) begin
                chk($sformatf("v%0d_rd", i), rf_write_Rd, vecs[i].exp_rd);
                chk($sformatf("v%0d_data", i), rf_write_data, vecs[i].exp_data);
            end
            chk($sformatf("v%0d_ready", i), in_ready, 1);
        end
        idle_in();
        step();
        chk("alu_wen_drop", rf_wen, 0);

        // load into r0: request issued, no write
        issue_load(4'd0, 32'h40);
        chk("r0_req", mem_req, 1);
        chk("r0_addr", mem_addr, 32'h40);
        step();
        mem_ack = 1; mem_rdata = 32'h12345678;
        step();
        mem_ack = 0;
        chk("r0_wen", rf_wen, 0);
        chk("r0_req_drop", mem_req, 0);
        chk("r0_ready", in_ready, 1);
        step();
        chk("r0_wen2", rf_wen, 0);

        // load with ack in the 5th wait cycle
        issue_load(4'd4, 32'h100);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("ld_req%0d", k), mem_req, 1);
            chk($sformatf("ld_addr%0d", k), mem_addr, 32'h100);
            chk($sformatf("ld_ready%0d", k), in_ready, 0);
            chk($sformatf("ld_busy%0d", k), busy, 1);
            chk($sformatf("ld_wen%0d", k), rf_wen, 0);
            if (k == 5) begin
                mem_ack = 1; mem_rdata = 32'hDEADBEEF;
            end
            step();
        end
        mem_ack = 0; mem_rdata = 0;
        chk("ld_wen", rf_wen, 1);
        chk("ld_rd", rf_write_Rd, 4);
        chk("ld_data", rf_write_data, 32'hDEADBEEF);
        chk("ld_ready", in_ready, 1);
        chk("ld_req_drop", mem_req, 0);
        step();
        chk("ld_wen_drop", rf_wen, 0);

        // timeout on the MEM_TIMEOUT=4 instance
        issue_load(4'd6, 32'h200);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("to_req%0d", k), t_mem_req, 1);
            chk($sformatf("to_addr%0d", k), t_mem_addr, 32'h200);
            chk($sformatf("to_err%0d", k), t_err, 0);
            chk($sformatf("to_ready%0d", k), t_ready, 0);
            step();
        end
        chk("to_req_drop", t_mem_req, 0);
        chk("to_err", t_err, 1);
        chk("to_wen", t_wen, 0);
        chk("to_ready", t_ready, 1);
        chk("to_busy", t_busy, 0);
        step();
        chk("to_err_pulse", t_err, 0);
        chk("to_wen2", t_wen, 0);

        // default instance is still waiting; reset both
        do_reset(1);
        step();

        // ack coincides with the 4th wait cycle: ack wins
        issue_load(4'd6, 32'h300);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ta_req%0d", k), t_mem_req, 1);
            if (k == 4) begin
                mem_ack = 1; mem_rdata = 32'hCAFEF00D;
            end
            step();
        end
        mem_ack = 0; mem_rdata = 0;
        chk("ta_wen", t_wen, 1);
        chk("ta_rd", t_rd, 6);
        chk("ta_data", t_data, 32'hCAFEF00D);
        chk("ta_err", t_err, 0);
        chk("ta_req_drop", t_mem_req, 0);
        step();
        chk("ta_err2", t_err, 0);

        // reset mid MEM_WAIT drops the pending load
        issue_load(4'd7, 32'h400);
        step();
        chk("mr_busy", busy, 1);
        do_reset(2);
        mem_ack = 1; mem_rdata = 32'h0BADF00D;
        step();
        mem_ack = 0;
        chk("mr_wen", rf_wen, 0);
        chk("mr_err", err_timeout, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", in_ready, 1);
        chk("mr_req", mem_req, 0);
        step();
        chk("mr_wen2", rf_wen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
